// File: rtl/plic_claim_agent.sv
// Per-context PLIC claim/complete initiator on the BRAM control port.
// Define PLIC_CLAIM_AGENT_INIT_EN to program the context enable mask once out of reset.
module plic_claim_agent #(
  parameter int unsigned CTX_ID          = 0,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] INIT_ENABLE     = 32'hFFFF_FFFE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        irq,
  output logic [21:0] bram_addr,
  output logic        bram_en,
  output logic        bram_we,
  output logic [31:0] bram_wrdata,
  input  logic [31:0] bram_rddata,
  output logic        claim_valid,
  input  logic        claim_ready,
  output logic [4:0]  claim_id,
  input  logic        complete_valid,
  output logic        complete_ready,
  input  logic [4:0]  complete_id,
  output logic [3:0]  outstanding,
  output logic [15:0] spurious_cnt
);

  localparam logic [21:0] CLAIM_ADDR = 22'h200004 + 22'(CTX_ID << 12);
  localparam logic [3:0]  MAX_OUT    = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
`ifdef PLIC_CLAIM_AGENT_INIT_EN
    INIT,
`endif
    IDLE, CLAIM_REQ, CLAIM_WAIT, PRESENT, COMPLETE_WR
  } state_t;

  state_t state;

`ifdef PLIC_CLAIM_AGENT_INIT_EN
  localparam logic [21:0] ENABLE_ADDR = 22'h002000 + 22'(CTX_ID << 7);
  localparam state_t      RST_STATE   = INIT;
  localparam logic        RST_READY   = 1'b0;
  logic init_issued;
  logic unused_bits;
  assign unused_bits = ^bram_rddata[31:5];
`else
  localparam state_t      RST_STATE   = IDLE;
  localparam logic        RST_READY   = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{bram_rddata[31:5], INIT_ENABLE};
`endif

  // All outputs are registered: each transition sets what the next state drives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= RST_STATE;
      bram_en        <= 1'b0;
      bram_we        <= 1'b0;
      bram_addr      <= '0;
      bram_wrdata    <= '0;
      claim_valid    <= 1'b0;
      claim_id       <= '0;
      complete_ready <= RST_READY;
      outstanding    <= '0;
      spurious_cnt   <= '0;
`ifdef PLIC_CLAIM_AGENT_INIT_EN
      init_issued    <= 1'b0;
`endif
    end else begin
      bram_en     <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
      case (state)
`ifdef PLIC_CLAIM_AGENT_INIT_EN
        INIT: begin
          if (!init_issued) begin
            init_issued <= 1'b1;
            bram_en     <= 1'b1;
            bram_we     <= 1'b1;
            bram_addr   <= ENABLE_ADDR;
            bram_wrdata <= INIT_ENABLE;
          end else begin
            state          <= IDLE;
            complete_ready <= 1'b1;
          end
        end
`endif
        IDLE: begin
          // Completion wins; a zero ID is swallowed without a bus write.
          if (complete_valid) begin
            if (complete_id != 5'd0) begin
              state          <= COMPLETE_WR;
              complete_ready <= 1'b0;
              bram_en        <= 1'b1;
              bram_we        <= 1'b1;
              bram_addr      <= CLAIM_ADDR;
              bram_wrdata    <= {27'b0, complete_id};
            end
          end else if (irq && (outstanding < MAX_OUT)) begin
            state          <= CLAIM_REQ;
            complete_ready <= 1'b0;
            bram_en        <= 1'b1;
            bram_addr      <= CLAIM_ADDR;
          end
        end
        CLAIM_REQ: state <= CLAIM_WAIT;
        CLAIM_WAIT: begin
          if (bram_rddata[4:0] != 5'd0) begin
            claim_id    <= bram_rddata[4:0];
            claim_valid <= 1'b1;
            state       <= PRESENT;
          end else begin
            if (spurious_cnt != 16'hFFFF) spurious_cnt <= spurious_cnt + 16'd1;
            state          <= IDLE;
            complete_ready <= 1'b1;
          end
        end
        PRESENT: begin
          if (claim_ready) begin
            claim_valid    <= 1'b0;
            outstanding    <= outstanding + 4'd1;
            state          <= IDLE;
            complete_ready <= 1'b1;
          end
        end
        COMPLETE_WR: begin
          if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
          state          <= IDLE;
          complete_ready <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          complete_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
